// File: rtl/adc_spi_pkg.sv
// rtl/adc_spi_pkg.sv - shared frame geometry and types for the ADC SPI frame reader
package adc_spi_pkg;

  localparam int FRAME_LEN  = 20;
  localparam int DATA_W     = 12;
  localparam int DATA_FIRST = 7;
  localparam int ADDR_FIRST = 2;
  localparam int CNT_W      = 5;

  typedef logic [DATA_W-1:0] sample_t;
  typedef logic [CNT_W-1:0]  count_t;

  localparam count_t CNT_LAST  = count_t'(FRAME_LEN - 1);
  localparam count_t CAP_FIRST = count_t'(DATA_FIRST);
  localparam count_t CAP_LAST  = count_t'(DATA_FIRST + DATA_W - 1);
  localparam count_t ADDR_BIT2 = count_t'(ADDR_FIRST);
  localparam count_t ADDR_BIT1 = count_t'(ADDR_FIRST + 1);
  localparam count_t ADDR_BIT0 = count_t'(ADDR_FIRST + 2);

endpackage

// File: rtl/adc_spi_frame_counter.sv
// rtl/adc_spi_frame_counter.sv - wrapping frame position counter with chip-select and channel-address decode
module adc_spi_frame_counter
  import adc_spi_pkg::*;
#(
  parameter logic [2:0] CHANNEL = 3'd0
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] count,
  output logic             cs,
  output logic             din
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (count == CNT_LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  // cs idles high only in slot 0; the channel address goes out MSB-first right after it
  always_comb begin
    cs  = (count == '0);
    din = 1'b0;
    if (count == ADDR_BIT2) begin
      din = CHANNEL[2];
    end else if (count == ADDR_BIT1) begin
      din = CHANNEL[1];
    end else if (count == ADDR_BIT0) begin
      din = CHANNEL[0];
    end
  end

endmodule

// File: rtl/adc_spi_frame_reader.sv
// rtl/adc_spi_frame_reader.sv - continuous 20-cycle SPI frame reader for a 12-bit ADC; optional ADC_SPI_DATA_VALID_EN adds data_valid
module adc_spi_frame_reader
  import adc_spi_pkg::*;
#(
  parameter logic [2:0] CHANNEL = 3'd0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dout,
  output logic              din,
  output logic              cs,
  output logic [CNT_W-1:0]  count,
  output logic [DATA_W-1:0] data_out
`ifdef ADC_SPI_DATA_VALID_EN
  ,
  output logic              data_valid
`endif
);

  sample_t shift;
  logic    in_window;

  adc_spi_frame_counter #(
    .CHANNEL(CHANNEL)
  ) u_counter (
    .clk  (clk),
    .rst  (rst),
    .count(count),
    .cs   (cs),
    .din  (din)
  );

  assign in_window = (count >= CAP_FIRST) && (count <= CAP_LAST);

  // shift is never cleared between frames: each frame rewrites all DATA_W bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift <= '0;
    end else if (in_window) begin
      shift <= {shift[DATA_W-2:0], dout};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out <= '0;
    end else if (count == CNT_LAST) begin
      data_out <= shift;
    end
  end

`ifdef ADC_SPI_DATA_VALID_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_valid <= 1'b0;
    end else begin
      data_valid <= (count == CNT_LAST);
    end
  end
`endif

endmodule

// File: tb/tb_adc_spi_frame_reader.sv
// tb/tb_adc_spi_frame_reader.sv - self-checking bench for adc_spi_frame_reader
module tb_adc_spi_frame_reader;

  localparam logic [2:0] TB_CHANNEL = 3'b101;

  logic        clk;
  logic        rst;
  logic        dout;
  logic        din;
  logic        cs;
  logic [4:0]  count;
  logic [11:0] data_out;
`ifdef ADC_SPI_DATA_VALID_EN
  logic        data_valid;
`endif

  adc_spi_frame_reader #(
    .CHANNEL(TB_CHANNEL)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .dout    (dout),
    .din     (din),
    .cs      (cs),
    .count   (count),
    .data_out(data_out)
`ifdef ADC_SPI_DATA_VALID_EN
    ,
    .data_valid(data_valid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] pat;
    logic [11:0] exp_word;
  } vec_t;

  vec_t        vecs[10];
  logic [11:0] sb_q[$];
  logic [11:0] last_pub;
  logic        pub_seen;
  int          n_cmp;
  int          n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endtask

  function automatic logic exp_din(input int c);
    if (c == 2) return TB_CHANNEL[2];
    if (c == 3) return TB_CHANNEL[1];
    if (c == 4) return TB_CHANNEL[0];
    return 1'b0;
  endfunction

  // bit k of the pattern is driven on dout while count == k
  function automatic logic [19:0] pat_from_word(input logic [11:0] w, input logic [19:0] noise);
    logic [19:0] p;
    p = noise & 20'h80040;
    for (int i = 0; i < 12; i++) p[7 + i] = w[11 - i];
    return p;
  endfunction

  // entered at a falling edge with count == 0; leaves at the falling edge after the publish
  task automatic run_frame(input logic [19:0] pat, input logic [11:0] exp_word);
    logic [11:0] want;
    sb_q.push_back(exp_word);
    for (int c = 0; c < 20; c++) begin
      check("count", 32'(count), 32'(c));
      check("cs", 32'(cs), 32'(c == 0));
      check("din", 32'(din), 32'(exp_din(c)));
      check("data_out_hold", 32'(data_out), 32'(last_pub));
`ifdef ADC_SPI_DATA_VALID_EN
      check("data_valid", 32'(data_valid), 32'((c == 0) && pub_seen));
`endif
      dout = pat[c];
      @(negedge clk);
    end
    dout = 1'b0;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scoreboard: got empty queue, expected one pending word");
    end else begin
      want = sb_q.pop_front();
      check("data_out_publish", 32'(data_out), 32'(want));
      check("count_wrap", 32'(count), 32'd0);
      check("cs_wrap", 32'(cs), 32'd1);
      last_pub = want;
    end
    pub_seen = 1'b1;
  endtask

  initial begin
    logic [11:0] rw;
    n_cmp    = 0;
    n_fail   = 0;
    last_pub = 12'h000;
    pub_seen = 1'b0;
    rst      = 1'b1;
    dout     = 1'b0;

    vecs[0] = '{20'h53B80, 12'hEE5};
    vecs[1] = '{20'h53B80, 12'hEE5};
    vecs[2] = '{20'h80040, 12'h000};
    vecs[3] = '{20'h00080, 12'h800};
    vecs[4] = '{20'h40000, 12'h001};
    vecs[5] = '{20'h7FF80, 12'hFFF};
    vecs[6] = '{20'h2AA80, 12'hAAA};
    rw = 12'($urandom);
    vecs[7] = '{pat_from_word(rw, 20'($urandom)), rw};
    rw = 12'($urandom);
    vecs[8] = '{pat_from_word(rw, 20'($urandom)), rw};
    vecs[9] = '{20'hFFFFF, 12'hFFF};

    repeat (3) @(negedge clk);
    check("rst_count", 32'(count), 32'd0);
    check("rst_cs", 32'(cs), 32'd1);
    check("rst_din", 32'(din), 32'd0);
    check("rst_data_out", 32'(data_out), 32'h000);
`ifdef ADC_SPI_DATA_VALID_EN
    check("rst_data_valid", 32'(data_valid), 32'd0);
`endif
    rst = 1'b0;

    for (int v = 0; v < 10; v++) begin
      run_frame(vecs[v].pat, vecs[v].exp_word);
    end

    // abort a frame part-way with ones on dout; nothing partial may surface
    for (int c = 0; c < 12; c++) begin
      dout = 1'b1;
      @(negedge clk);
    end
    check("mid_count_before_rst", 32'(count), 32'd12);
    rst = 1'b1;
    #1;
    check("mid_rst_data_out", 32'(data_out), 32'h000);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_cs", 32'(cs), 32'd1);
    repeat (2) @(negedge clk);
    check("mid_rst_hold_count", 32'(count), 32'd0);
    check("mid_rst_hold_data", 32'(data_out), 32'h000);
`ifdef ADC_SPI_DATA_VALID_EN
    check("mid_rst_data_valid", 32'(data_valid), 32'd0);
`endif
    dout     = 1'b0;
    rst      = 1'b0;
    last_pub = 12'h000;
    pub_seen = 1'b0;
    run_frame(20'hFFFFF, 12'hFFF);
    run_frame(20'h40000, 12'h001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_spi_frame_reader.md
Name: adc_spi_frame_reader

Overview:
- Fixed-frame SPI master for a 12-bit serial ADC (ADC128S022-class).
- Repeats a 20-cycle conversion frame continuously:
  - drives chip-select and the channel-address bits on din;
  - shifts 12 result bits MSB-first from dout;
  - publishes the word on data_out at frame end.
- Sits between the ADC pins and sensor-processing logic; the ADC serial clock is the same clk, routed externally.

Parameters:
- FRAME_LEN, 20, clk cycles per frame; count runs 0..FRAME_LEN-1.
- DATA_W, 12, result width.
- DATA_FIRST, 7, count value at which the first (MSB) data bit is sampled.
- CHANNEL, 3'd0, ADC channel address driven on din.

Ports:
- clk  input  1  system clock, also ADC serial clock; all registers on rising edge.
- rst  input  1  asynchronous, active-high reset.
- dout  input  1  serial data from ADC (MISO).
- din  output  1  serial data to ADC (MOSI), channel address.
- cs  output  1  ADC chip-select, active low.
- count  output  5  current frame position.
- data_out  output  DATA_W  last completed conversion result.

Behaviour:
- Reset values while rst=1: count=0, shift register=0, data_out=0. Hence cs=1 and din=0.
- Reset asserted mid-frame aborts the frame immediately. No partial result reaches data_out. The first frame after release starts at count=0.
- count: increments by 1 each rising edge; 19 -> 0 (wrap). No stall or enable input.
- cs: combinational, cs = (count == 0). It is high for exactly 1 cycle per frame and low for counts 1..19.
- din: combinational from count:
  - count 2 -> CHANNEL[2];
  - count 3 -> CHANNEL[1];
  - count 4 -> CHANNEL[0];
  - otherwise 0.
- Capture: at a rising edge where count is in DATA_FIRST..DATA_FIRST+DATA_W-1 (7..18), shift <= {shift[DATA_W-2:0], dout}. The bit sampled at count 7 ends up as data_out[11] (MSB-first).
- dout is ignored outside the capture window, including the leading null bit at count 6 and the trailing bit at count 19.
- Publish: at the rising edge where count==19, data_out <= shift, which now holds all 12 bits. data_out holds that value for the whole next frame.
- Latency: result available 1 cycle after the last data bit; one new sample every 20 cycles.
- Shift register is not cleared between frames; every frame overwrites all 12 bits.
- Width rule: count is 5 bits, FRAME_LEN must be <= 32, and DATA_FIRST+DATA_W must be <= FRAME_LEN-1.

Optional Feature:
- Macro ADC_SPI_DATA_VALID_EN.
- Defined: extra output port data_valid (1 bit), reset 0. It is registered high for exactly one cycle, the cycle in which data_out has just been updated (the cycle with count==0), and low otherwise.
- Undefined: the port does not exist; all other behaviour is identical.

Decomposition:
- Shared package adc_spi_pkg holds:
  - localparams FRAME_LEN, DATA_W, DATA_FIRST, ADDR_FIRST=2;
  - a count-width constant (5);
  - a typedef for the 12-bit sample word.
- One natural sub-module, adc_spi_frame_counter: the wrapping 0..FRAME_LEN-1 counter plus cs/din decode.
- Shift and publish logic stays in the top module.

Test Plan:
- Reset: hold rst=1 for 3 clks -> count=0, cs=1, din=0, data_out=0x000. Release -> count goes 1,2,3… and cs falls after the first edge.
- Frame capture: drive dout for sample counts 7..18 as 1,1,1,0,1,1,1,0,0,1,0,1, with count 6 = 0 and count 19 = 0. After the edge at count 19 -> data_out=0xEE5, count=0, cs=1.
- Back-to-back frames: repeat the same pattern for a second frame -> data_out stays 0xEE5 throughout frame 2 and re-publishes 0xEE5 at its end. count wraps 19->0 exactly every 20 clks.
- Window boundaries: dout=1 only at counts 6 and 19, 0 elsewhere -> data_out=0x000. dout=1 only at count 7 -> 0x800. dout=1 only at count 18 -> 0x001.
- Channel address: CHANNEL=3'b101 -> din=1 at count 2, 0 at count 3, 1 at count 4, 0 at all other counts.
- Reset mid-frame: assert rst at count 12 with a partial pattern -> data_out=0x000 immediately, and the next full frame with all-ones dout -> data_out=0xFFF. With ADC_SPI_DATA_VALID_EN, data_valid pulses once per frame at count 0 and never during reset.
